rf_writeback: RTL and testbench

//  Write-side controller for the 32x32 register file: collects results from the ALU and load/store

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/rf_writeback.sv | 160 ++++++++++++++++
 tb/tb_rf_writeback.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared widths and the writeback buffer entry type for the register-file write side.
package rf_wb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int WB_AW    = 5;
    localparam int WB_DEPTH = 2;

    typedef struct packed {
        logic [WB_AW-1:0]   rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; storage and read pointer are exposed so the
// owner can search buffered results for operand bypass.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH   = WB_DEPTH,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 push,
    input  logic                 pop,
    input  entry_t               din,
    output entry_t               head,
    output logic [PW:0]          count,
    output logic                 full,
    output logic                 empty,
    output logic [PW-1:0]        rd_ptr,
    output entry_t [DEPTH-1:0]   entries
);

    localparam int CW = PW + 1;

    entry_t [DEPTH-1:0] mem;
    logic   [PW-1:0]    wr_ptr;

    // Callers never push while full or pop while empty; pointers wrap naturally (DEPTH is 2**PW).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign entries = mem;

endmodule

// File: rtl/rf_writeback.sv
// Regfile write-side controller: LSU/ALU arbitration, writeback buffer, registered write port,
// busy scoreboard. Operand bypass from pending writes is built only when WB_BYPASS_EN is defined.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int XLEN  = WB_XLEN,
    parameter int AW    = WB_AW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [AW-1:0]      lsu_rd,
    input  logic [XLEN-1:0]    lsu_data,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    output logic [2**AW-1:0]   busy_vec,
    output logic               rf_wr_en,
    output logic [AW-1:0]      rf_wr_addr,
    output logic [XLEN-1:0]    rf_wrdata,
    input  logic [AW-1:0]      byp_addr1,
    input  logic [AW-1:0]      byp_addr2,
    output logic               byp_hit1,
    output logic               byp_hit2,
    output logic [XLEN-1:0]    byp_data1,
    output logic [XLEN-1:0]    byp_data2
);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } entry_t;

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**AW;

    entry_t               din;
    entry_t               head;
    entry_t [DEPTH-1:0]   entries;
    logic   [PW:0]        count;
    logic   [PW-1:0]      rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 lsu_fire;
    logic                 alu_fire;

    // Ready looks only at the registered fill level, never at this cycle's drain.
    assign lsu_ready = !full;
    assign alu_ready = !full && !lsu_valid;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && alu_ready;

    // Results targeting x0 complete the handshake but are dropped here.
    always_comb begin
        din  = '0;
        push = 1'b0;
        if (lsu_fire) begin
            din.rd   = lsu_rd;
            din.data = lsu_data;
            push     = (lsu_rd != '0);
        end else if (alu_fire) begin
            din.rd   = alu_rd;
            din.data = alu_data;
            push     = (alu_rd != '0);
        end
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (push),
        .pop     (!empty),
        .din     (din),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .rd_ptr  (rd_ptr),
        .entries (entries)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wrdata  <= '0;
        end else begin
            rf_wr_en <= !empty;
            if (!empty) begin
                rf_wr_addr <= head.rd;
                rf_wrdata  <= head.data;
            end
        end
    end

    logic [NREG-1:0] busy_next;

    // Clear on the commit edge first, then set, so a same-edge reissue keeps the bit high.
    always_comb begin
        busy_next = busy_vec;
        if (rf_wr_en) begin
            busy_next[rf_wr_addr] = 1'b0;
        end
        if (iss_valid && iss_rd != '0) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

`ifdef WB_BYPASS_EN
    // In-flight write is oldest; buffer entries are scanned oldest to youngest so the youngest wins.
    function automatic logic [XLEN:0] byp_lookup(input logic [AW-1:0] addr);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        if (addr != '0) begin
            if (rf_wr_en && rf_wr_addr == addr) begin
                res = {1'b1, rf_wrdata};
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if (CW'(k) < count && entries[idx].rd == addr) begin
                    res = {1'b1, entries[idx].data};
                end
            end
        end
        return res;
    endfunction

    assign {byp_hit1, byp_data1} = byp_lookup(byp_addr1);
    assign {byp_hit2, byp_data2} = byp_lookup(byp_addr2);
`else
    logic unused_byp;

    assign unused_byp = ^{byp_addr1, byp_addr2, entries, rd_ptr, count};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: queue-based reference model compared every cycle, plus directed literal checks.
module tb_rf_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy_vec;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wrdata;
    logic [4:0]  byp_addr1, byp_addr2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;

    int total = 0;
    int bad   = 0;

    rf_writeback dut (
        .clk        (clk),
        .nrst       (nrst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .busy_vec   (busy_vec),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wrdata  (rf_wrdata),
        .byp_addr1  (byp_addr1),
        .byp_addr2  (byp_addr2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    bit          alu_acc, lsu_acc;
    logic [4:0]  wr_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
        alu_acc = 1'b0; lsu_acc = 1'b0;
    endtask

    // One clock edge of the writeback contract, evaluated from pre-edge state and inputs.
    task automatic model_step();
        int   n;
        ent_t e;
        alu_acc = 1'b0;
        lsu_acc = 1'b0;
        if (!nrst) return;
        n = q.size();
        if (m_en) m_busy[m_addr] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        if (n > 0) begin
            e = q.pop_front();
            m_en = 1'b1; m_addr = e.rd; m_data = e.data;
        end else begin
            m_en = 1'b0;
        end
        if (n < DEPTH) begin
            if (lsu_valid) begin
                lsu_acc = 1'b1;
                if (lsu_rd != 0) q.push_back('{lsu_rd, lsu_data});
            end else if (alu_valid) begin
                alu_acc = 1'b1;
                if (alu_rd != 0) q.push_back('{alu_rd, alu_data});
            end
        end
    endtask

    function automatic logic [32:0] exp_byp(input logic [4:0] a);
`ifdef WB_BYPASS_EN
        if (a == 0) return 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == a) return {1'b1, q[i].data};
        if (m_en && m_addr == a) return {1'b1, m_data};
`endif
        return 33'd0;
    endfunction

    task automatic compare_all();
        chk("lsu_ready", lsu_ready, q.size() < DEPTH);
        chk("alu_ready", alu_ready, (q.size() < DEPTH) && !lsu_valid);
        chk("rf_wr_en", rf_wr_en, m_en);
        if (m_en) begin
            chk("rf_wr_addr", rf_wr_addr, m_addr);
            chk("rf_wrdata", rf_wrdata, m_data);
        end
        chk("busy_vec", busy_vec, m_busy);
        chk("byp1", {byp_hit1, byp_data1}, exp_byp(byp_addr1));
        chk("byp2", {byp_hit2, byp_data2}, exp_byp(byp_addr2));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (rf_wr_en) wr_log.push_back(rf_wr_addr);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    initial begin
        nrst = 1'b0;
        idle_inputs();
        byp_addr1 = 0; byp_addr2 = 0;
        model_reset();
        #2;
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_wr_addr", rf_wr_addr, 0);
        chk("rst_wrdata", rf_wrdata, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_byp", {byp_hit1, byp_hit2}, 0);
        cycle();
        cycle();
        nrst = 1'b1;
        cycle();

        // Single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 0;
        cycle();
        chk("t2_wr_en", rf_wr_en, 1);
        chk("t2_addr", rf_wr_addr, 5);
        chk("t2_data", rf_wrdata, 32'hDEADBEEF);
        cycle();
        chk("t2_wr_en_off", rf_wr_en, 0);

        // Contention: LSU first, ALU next cycle
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h22;
        #1;
        chk("t3_alu_blocked", alu_ready, 0);
        chk("t3_lsu_ready", lsu_ready, 1);
        cycle();
        lsu_valid = 0;
        cycle();
        chk("t3_first_addr", rf_wr_addr, 4);
        chk("t3_first_data", rf_wrdata, 32'h22);
        alu_valid = 0;
        cycle();
        chk("t3_second_en", rf_wr_en, 1);
        chk("t3_second_addr", rf_wr_addr, 3);
        chk("t3_second_data", rf_wrdata, 32'h11);
        cycle();
        chk("t3_idle", rf_wr_en, 0);

        // Scoreboard and x0
        iss_valid = 1; iss_rd = 7;
        cycle();
        iss_valid = 0;
        chk("t5_busy_set", busy_vec[7], 1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        cycle();
        alu_valid = 0;
        cycle();
        chk("t5_busy_during_write", busy_vec[7], 1);
        cycle();
        chk("t5_busy_cleared", busy_vec[7], 0);
        iss_valid = 1; iss_rd = 7;
        cycle();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
        cycle();
        alu_valid = 0;
        cycle();
        chk("t5_inflight7", {rf_wr_en, rf_wr_addr}, {1'b1, 5'd7});
        iss_valid = 1; iss_rd = 7;
        cycle();
        iss_valid = 0;
        chk("t5_set_wins", busy_vec[7], 1);
        cycle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        #1;
        chk("t5_x0_ready", alu_ready, 1);
        cycle();
        alu_valid = 0;
        cycle();
        chk("t5_x0_no_write", rf_wr_en, 0);
        cycle();
        chk("t5_x0_no_write2", rf_wr_en, 0);

        // Bypass: two writes to x9, youngest wins; x0 never hits
        byp_addr1 = 9; byp_addr2 = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'hA;
        cycle();
        alu_rd = 9; alu_data = 32'hB;
        cycle();
        alu_valid = 0;
`ifdef WB_BYPASS_EN
        chk("t6_hit1", byp_hit1, 1);
        chk("t6_data1", byp_data1, 32'hB);
`else
        chk("t6_hit1_off", byp_hit1, 0);
        chk("t6_data1_off", byp_data1, 0);
`endif
        chk("t6_hit2", byp_hit2, 0);
        cycle();
        cycle();
        cycle();

        // Back-to-back stream x1..x6
        wr_log.delete();
        for (int i = 1; i <= 6; i++) begin
            int w;
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h100 * i;
            w = 0;
            do begin
                cycle();
                w++;
            end while (!alu_acc && w < 8);
            chk("t4_accept", alu_acc, 1);
        end
        alu_valid = 0;
        repeat (4) cycle();
        chk("t4_count", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            chk("t4_order", wr_log[i], i + 1);

        // Reset mid-stream with one buffered and one in-flight write
        iss_valid = 1; iss_rd = 12;
        alu_valid = 1; alu_rd = 10; alu_data = 32'hAA;
        cycle();
        iss_valid = 0; alu_valid = 0;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hBB;
        cycle();
        chk("t1_pre_busy", busy_vec[12], 1);
        nrst = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("t1_wr_en", rf_wr_en, 0);
        chk("t1_addr", rf_wr_addr, 0);
        chk("t1_data", rf_wrdata, 0);
        chk("t1_busy", busy_vec, 0);
        chk("t1_byp", {byp_hit1, byp_hit2}, 0);
        cycle();
        cycle();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_no_write", rf_wr_en, 0);
        end

        // Randomized traffic with holds on unaccepted sources
        for (int c = 0; c < 3000; c++) begin
            if (!lsu_valid || lsu_acc) begin
                lsu_valid = ($urandom_range(0, 2) == 0);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            if (!alu_valid || alu_acc) begin
                alu_valid = ($urandom_range(0, 1) == 0);
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 7));
            byp_addr1 = 5'($urandom_range(0, 7));
            byp_addr2 = 5'($urandom_range(0, 7));
            if (c == 1500) begin
                nrst = 1'b0;
                idle_inputs();
                model_reset();
                cycle();
                nrst = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
